// File: rtl/fb_mdu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fb_mdu_pkg : shared op/flag indices, state encoding and defaults for fb_mdu |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package fb_mdu_pkg;

  localparam int XLEN_DEF = 32;
  localparam int OP_W_DEF = 8;

  localparam int OP_MUL    = 0;
  localparam int OP_MULH   = 1;
  localparam int OP_MULHSU = 2;
  localparam int OP_MULHU  = 3;
  localparam int OP_DIV    = 4;
  localparam int OP_DIVU   = 5;
  localparam int OP_REM    = 6;
  localparam int OP_REMU   = 7;

  localparam int CSR_ZERO = 0;
  localparam int CSR_NEG  = 1;
  localparam int CSR_DZ   = 2;
  localparam int CSR_OVF  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fb_mdu_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fb_mdu_if : request/response handshake bundle of the multiply/divide unit  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface fb_mdu_if
  import fb_mdu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int OP_W = OP_W_DEF
);

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] mdu_control;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] mdu_res;
  logic [3:0]      csr;
  logic            csr_write;

  modport master (
    output flush, in_valid, mdu_control, op1, op2, out_ready,
    input  in_ready, out_valid, mdu_res, csr, csr_write
  );

  modport slave (
    input  flush, in_valid, mdu_control, op1, op2, out_ready,
    output in_ready, out_valid, mdu_res, csr, csr_write
  );

endinterface
`default_nettype wire

// File: rtl/fb_mdu_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fb_mdu_step : one shift-add (mul) or restoring trial-subtract (div) step   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module fb_mdu_step #(
  parameter int XLEN = 32
) (
  input  wire logic              i_is_div,
  input  wire logic [2*XLEN-1:0] i_acc,
  input  wire logic [XLEN-1:0]   i_opnd,
  output logic      [2*XLEN-1:0] o_acc
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_shl;
  logic [XLEN:0] w_trial;

  // mul: acc = {partial, multiplier}; div: acc = {remainder, dividend/quotient}
  assign w_sum   = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
  assign w_shl   = {i_acc[2*XLEN-1:XLEN], i_acc[XLEN-1]};
  assign w_trial = w_shl - {1'b0, i_opnd};

  always_comb begin
    o_acc = {w_sum, i_acc[XLEN-1:1]};
    if (i_is_div) begin
      if (!w_trial[XLEN]) o_acc = {w_trial[XLEN-1:0], i_acc[XLEN-2:0], 1'b1};
      else                o_acc = {w_shl[XLEN-1:0], i_acc[XLEN-2:0], 1'b0};
    end
  end

endmodule
`default_nettype wire

// File: rtl/fb_mdu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fb_mdu : iterative RV32M/RV64M multiply/divide unit with valid/ready I/O    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module fb_mdu
  import fb_mdu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int OP_W = OP_W_DEF
) (
  input wire logic clk,
  input wire logic rst_n,
  fb_mdu_if.slave  bus
);

  localparam int CNT_W = $clog2(XLEN);

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*XLEN-1:0]   r_acc, w_acc_nxt;
  logic [XLEN-1:0]     r_opnd, r_res;
  logic [OP_W-1:0]     r_op;
  logic                r_neg_q, r_neg_r;
  logic [3:0]          r_csr;

  logic [OP_W-1:0]     w_ctl;
  logic                w_accept, w_legal, w_is_div, w_quo_op, w_s1, w_s2;
  logic                w_neg1, w_neg2, w_div0, w_ovf, w_fast;
  logic [XLEN-1:0]     w_mag1, w_mag2, w_fast_res, w_fix_res, w_quo, w_rem;
  logic [2*XLEN-1:0]   w_prod;

  function automatic logic [1:0] res_flags(input logic [XLEN-1:0] v);
    return {v[XLEN-1], v == '0};
  endfunction

  assign w_ctl    = bus.mdu_control;
  assign w_accept = bus.in_valid && (r_state == ST_IDLE) && !bus.flush;
  assign w_legal  = $onehot(w_ctl);
  assign w_is_div = |w_ctl[OP_REMU:OP_DIV];
  assign w_quo_op = w_ctl[OP_DIV] | w_ctl[OP_DIVU];
  assign w_s1     = w_ctl[OP_MUL] | w_ctl[OP_MULH] | w_ctl[OP_MULHSU] | w_ctl[OP_DIV] | w_ctl[OP_REM];
  assign w_s2     = w_ctl[OP_MUL] | w_ctl[OP_MULH] | w_ctl[OP_DIV] | w_ctl[OP_REM];
  assign w_neg1   = w_s1 & bus.op1[XLEN-1];
  assign w_neg2   = w_s2 & bus.op2[XLEN-1];
  assign w_mag1   = w_neg1 ? -bus.op1 : bus.op1;
  assign w_mag2   = w_neg2 ? -bus.op2 : bus.op2;
  assign w_div0   = w_legal & w_is_div & (bus.op2 == '0);
  assign w_ovf    = w_legal & (w_ctl[OP_DIV] | w_ctl[OP_REM]) &
                    (bus.op1 == {1'b1, {(XLEN-1){1'b0}}}) & (bus.op2 == '1);
  assign w_fast   = !w_legal | w_div0 | w_ovf;

  always_comb begin
    w_fast_res = '0;
    if (w_div0)     w_fast_res = w_quo_op ? '1 : bus.op1;
    else if (w_ovf) w_fast_res = w_quo_op ? bus.op1 : '0;
  end

  fb_mdu_step #(.XLEN(XLEN)) u_step (
    .i_is_div (|r_op[OP_REMU:OP_DIV]),
    .i_acc    (r_acc),
    .i_opnd   (r_opnd),
    .o_acc    (w_acc_nxt)
  );

  // r_neg_q: product/quotient sign; r_neg_r: remainder follows the dividend
  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_neg_q ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem  = r_neg_r ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_fix_res = w_rem;
    if (|r_op[OP_MULHU:OP_MUL])
      w_fix_res = r_op[OP_MUL] ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    else if (r_op[OP_DIV] | r_op[OP_DIVU])
      w_fix_res = w_quo;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_fast ? ST_DONE : ST_CALC;
      ST_CALC: if (r_cnt == CNT_W'(XLEN-1)) w_state_nxt = ST_FIX;
      ST_FIX:  w_state_nxt = ST_DONE;
      ST_DONE: if (bus.out_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (bus.flush) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_opnd  <= '0;
      r_res   <= '0;
      r_op    <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_csr   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_op    <= w_ctl;
          r_cnt   <= '0;
          r_neg_q <= w_neg1 ^ w_neg2;
          r_neg_r <= w_neg1;
          r_acc   <= {{XLEN{1'b0}}, (w_is_div ? w_mag1 : w_mag2)};
          r_opnd  <= w_is_div ? w_mag2 : w_mag1;
          if (w_fast) begin
            r_res <= w_fast_res;
            r_csr <= w_legal ? {w_ovf, w_div0, res_flags(w_fast_res)} : 4'b0000;
          end
        end
        ST_CALC: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt + 1'b1;
        end
        ST_FIX: begin
          r_res <= w_fix_res;
          r_csr <= {2'b00, res_flags(w_fix_res)};
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE) && !bus.flush;
  assign bus.mdu_res   = r_res;
  assign bus.csr       = r_csr;
  assign bus.csr_write = bus.out_valid && (r_csr[CSR_OVF] || r_csr[CSR_DZ]);

endmodule
`default_nettype wire

// File: tb/tb_fb_mdu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fb_mdu : randomized and directed checks of fb_mdu against a plain model |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_fb_mdu;

  logic clk;
  logic rst_n;
  int   n_total = 0;
  int   n_bad   = 0;

  fb_mdu_if #(.XLEN(32), .OP_W(8)) bus ();

  fb_mdu #(.XLEN(32), .OP_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: RISC-V M semantics via 64-bit arithmetic
  function automatic void ref_mdu(input logic [7:0] ctl, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic [3:0] csr, output int lat);
    longint      sa, sb;
    logic [63:0] p;
    bit          dz, ov;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = '0; dz = 0; ov = 0; p = '0;
    if (!$onehot(ctl)) begin
      csr = 4'b0000;
      lat = 1;
    end else begin
      if (ctl[0]) begin
        p = sa * sb; res = p[31:0];
      end else if (ctl[1]) begin
        p = sa * sb; res = p[63:32];
      end else if (ctl[2]) begin
        p = sa * longint'({32'h0, b}); res = p[63:32];
      end else if (ctl[3]) begin
        p = {32'h0, a} * {32'h0, b}; res = p[63:32];
      end else if (ctl[4] || ctl[6]) begin
        if (b == 0) begin
          dz = 1; res = ctl[4] ? 32'hFFFF_FFFF : a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          ov = 1; res = ctl[4] ? a : 32'h0;
        end else begin
          p = ctl[4] ? sa / sb : sa % sb; res = p[31:0];
        end
      end else begin
        if (b == 0) begin
          dz = 1; res = ctl[5] ? 32'hFFFF_FFFF : a;
        end else begin
          res = ctl[5] ? a / b : a % b;
        end
      end
      csr = {ov, dz, res[31], res == 32'h0};
      lat = (dz || ov) ? 1 : 34;
    end
  endfunction

  task automatic drive_accept(input logic [7:0] ctl, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid    = 1'b1;
    bus.mdu_control = ctl;
    bus.op1         = a;
    bus.op2         = b;
    @(posedge clk); #1;
    bus.in_valid    = 1'b0;
  endtask

  task automatic wait_result(input string tag, input logic [31:0] er, input logic [3:0] ec,
                             input int elat, input int hold, input bit retire);
    int lat;
    bit rdy_seen;
    lat = 1;
    rdy_seen = 0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready) rdy_seen = 1;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " lat"}, lat, elat);
    check({tag, " busy"}, rdy_seen, 0);
    check({tag, " res"}, bus.mdu_res, er);
    check({tag, " csr"}, bus.csr, ec);
    check({tag, " csr_write"}, bus.csr_write, (ec[3] | ec[2]));
    check({tag, " in_ready"}, bus.in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " hold valid"}, bus.out_valid, 1);
      check({tag, " hold res"}, bus.mdu_res, er);
      check({tag, " hold csr"}, bus.csr, ec);
    end
    if (retire) begin
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check({tag, " retire valid"}, bus.out_valid, 0);
      check({tag, " retire ready"}, bus.in_ready, 1);
    end
  endtask

  task automatic run_dir(input string tag, input logic [7:0] ctl, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input logic [3:0] ec,
                         input int elat, input int hold);
    drive_accept(ctl, a, b);
    wait_result(tag, er, ec, elat, hold, 1'b1);
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [7:0]  ctl;
    logic [31:0] a, b, er;
    logic [3:0]  ec;
    int          elat;
    bit          seen;

    rst_n = 1'b0;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.mdu_control = '0;
    bus.op1 = '0; bus.op2 = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("rst in_ready", bus.in_ready, 1);
    check("rst out_valid", bus.out_valid, 0);
    check("rst res", bus.mdu_res, 0);
    check("rst csr", bus.csr, 0);
    check("rst csr_write", bus.csr_write, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_dir("mul",       8'h01, 32'd7,        32'd5,        32'd35,       4'b0000, 34, 0);
    run_dir("mulh",      8'h02, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        4'b0001, 34, 0);
    run_dir("mulhu",     8'h08, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b0010, 34, 0);
    run_dir("mulhsu",    8'h04, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 4'b0010, 34, 0);
    run_dir("div",       8'h10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 4'b0010, 34, 0);
    run_dir("rem",       8'h40, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 4'b0010, 34, 0);
    run_dir("divu hold", 8'h20, 32'd100,      32'd7,        32'd14,       4'b0000, 34, 10);
    run_dir("remu",      8'h80, 32'd100,      32'd7,        32'd2,        4'b0000, 34, 0);
    run_dir("divu by0",  8'h20, 32'd5,        32'd0,        32'hFFFFFFFF, 4'b0110, 1,  0);
    run_dir("rem by0",   8'h40, 32'd5,        32'd0,        32'd5,        4'b0100, 1,  0);
    run_dir("div ovf",   8'h10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'b1010, 1,  0);
    run_dir("rem ovf",   8'h40, 32'h80000000, 32'hFFFFFFFF, 32'h0,        4'b1001, 1,  0);
    run_dir("illegal0",  8'h00, 32'd3,        32'd4,        32'h0,        4'b0000, 1,  0);
    run_dir("illegal2",  8'h03, 32'd3,        32'd4,        32'h0,        4'b0000, 1,  0);

    // flush together with in_valid in IDLE must not accept
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.mdu_control = 8'h01;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    check("flush idle no accept", bus.in_ready, 1);

    // flush at CALC iteration 10
    drive_accept(8'h01, 32'd9, 32'd9);
    repeat (10) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush calc ready", bus.in_ready, 1);
    check("flush calc valid", bus.out_valid, 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid) seen = 1;
      @(posedge clk); #1;
    end
    check("flush no result", seen, 0);

    // reset in the middle of CALC, after a nonzero result was left in the output
    run_dir("pre-rst", 8'h01, 32'd7, 32'd5, 32'd35, 4'b0000, 34, 0);
    drive_accept(8'h20, 32'd1000, 32'd3);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst valid", bus.out_valid, 0);
    check("midrst res", bus.mdu_res, 0);
    check("midrst csr", bus.csr, 0);
    check("midrst csr_write", bus.csr_write, 0);
    check("midrst ready", bus.in_ready, 1);

    // retire cycle with in_valid high: accept only on the following cycle
    drive_accept(8'h01, 32'd123, 32'd456);
    wait_result("b2b first", 32'd56088, 4'b0000, 34, 0, 1'b0);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.mdu_control = 8'h20; bus.op1 = 32'd1000; bus.op2 = 32'd7;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("b2b retire no accept", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_result("b2b second", 32'd142, 4'b0000, 34, 0, 1'b1);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 19) == 0) ctl = 8'($urandom);
      else                            ctl = 8'h01 << $urandom_range(0, 7);
      a = rand_opnd();
      b = rand_opnd();
      ref_mdu(ctl, a, b, er, ec, elat);
      drive_accept(ctl, a, b);
      wait_result($sformatf("rnd%0d ctl=%02h", n, ctl), er, ec, elat, $urandom_range(0, 3), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
